// File: rtl/sdspi_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sdspi_arbiter_pkg
//   Shared definitions for the sdspihost two-requester arbiter:
//   - arbiter state encoding
//   - command strobe vector width and bit positions
//   - round-robin winner selection helper
// ---------------------------------------------------------------------------
package sdspi_arbiter_pkg;

    // Command strobe vector: {r_multi_block, r_block, r_byte, w_block, w_byte}
    localparam int CMD_W       = 5;
    localparam int CMD_W_BYTE  = 0;
    localparam int CMD_W_BLOCK = 1;
    localparam int CMD_R_BYTE  = 2;
    localparam int CMD_R_BLOCK = 3;
    localparam int CMD_R_MULTI = 4;

    typedef logic [CMD_W-1:0] cmd_t;

    typedef enum logic [2:0] {
        ST_INIT_RST  = 3'd0,
        ST_INIT_WAIT = 3'd1,
        ST_IDLE      = 3'd2,
        ST_OWN       = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_ERR_HOLD  = 3'd5
    } state_e;

    // Winner of an arbitration round: a lone requester always wins, and when
    // both ask the priority pointer decides. Returns the requester index.
    function automatic logic pick_winner(input logic req0,
                                         input logic req1,
                                         input logic ptr);
        logic winner;
        if (req0 && req1) begin
            winner = ptr;
        end else begin
            winner = req1 && !req0;
        end
        return winner;
    endfunction

endpackage : sdspi_arbiter_pkg

// File: rtl/sdspi_arbiter_busy_watchdog.sv
// ---------------------------------------------------------------------------
// sdspi_arbiter_busy_watchdog
//   Counts consecutive enabled cycles and pulses expire_o on the cycle the
//   counter sits at all-ones, i.e. after 2^TIMEOUT_W enabled cycles.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   clr_i     clear the count (wins over en_i)
//   en_i      count this cycle
//   expire_o  one-cycle expiry pulse
// ---------------------------------------------------------------------------
module sdspi_arbiter_busy_watchdog #(
    parameter int TIMEOUT_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TIMEOUT_W-1:0] cnt_q;

    assign expire_o = en_i && !clr_i && (&cnt_q);

    // NOTE: reset is sampled on the clock edge, and all state is updated with
    // non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;  // wraps to zero on expiry
        end
    end

endmodule : sdspi_arbiter_busy_watchdog

// File: rtl/sdspi_arbiter.sv
// ---------------------------------------------------------------------------
// sdspi_arbiter
//   Grants the single sdspihost to one of two requesters per session with
//   round-robin priority, owns host reset/initialisation, forwards the owner's
//   commands with one registered cycle and recovers the host after an SD error
//   or a stuck-busy watchdog expiry.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req0/1                      session request, held for the whole session
//   cmd0/1                      {r_multi_block, r_block, r_byte, w_block, w_byte}
//   addr0/1, wdata0/1           block address and write byte per requester
//   grant0/1                    session granted
//   busy0/1                     spi_busy when granted, else 1
//   err0/1                      sticky error for current/last session
//   rdata                       host read data (meaningful to owner only)
//   init_done                   host initialised
//   timeout                     sticky watchdog flag (cleared by rst only)
//   spi_*                       sdspihost control / status
// ---------------------------------------------------------------------------
module sdspi_arbiter
    import sdspi_arbiter_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int TIMEOUT_W  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [CMD_W-1:0] cmd0,
    input  logic [CMD_W-1:0] cmd1,
    input  logic [31:0]      addr0,
    input  logic [31:0]      addr1,
    input  logic [7:0]       wdata0,
    input  logic [7:0]       wdata1,
    output logic             grant0,
    output logic             grant1,
    output logic             busy0,
    output logic             busy1,
    output logic             err0,
    output logic             err1,
    output logic [7:0]       rdata,
    output logic             init_done,
    output logic             timeout,
    output logic             spi_rst,
    output logic             spi_r_block,
    output logic             spi_r_multi_block,
    output logic             spi_r_byte,
    output logic             spi_w_block,
    output logic             spi_w_byte,
    output logic [31:0]      spi_block_addr,
    output logic [7:0]       spi_data_in,
    input  logic             spi_busy,
    input  logic             spi_err,
    input  logic             spi_crc_err,
    input  logic [7:0]       spi_data_out
);

    localparam int RST_CNT_W = $clog2(RST_CYCLES + 1);
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);

    state_e               state_q, state_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic                 ptr_q, ptr_d;       // requester favoured on a tie
    logic                 owner_q, owner_d;   // current/last session owner
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           err_q, err_d;
    logic                 init_done_q, init_done_d;
    logic                 timeout_q, timeout_d;
    cmd_t                 spi_cmd_q, spi_cmd_d;
    logic [31:0]          spi_addr_q, spi_addr_d;
    logic [7:0]           spi_wdata_q, spi_wdata_d;

    logic                 owner_req;
    cmd_t                 owner_cmd;
    logic [31:0]          owner_addr;
    logic [7:0]           owner_wdata;
    logic                 host_err;
    logic                 wd_en;
    logic                 wd_expire;
    logic                 winner;

    assign owner_req   = owner_q ? req1   : req0;
    assign owner_cmd   = owner_q ? cmd1   : cmd0;
    assign owner_addr  = owner_q ? addr1  : addr0;
    assign owner_wdata = owner_q ? wdata1 : wdata0;
    assign host_err    = spi_err || spi_crc_err;
    assign winner      = pick_winner(req0, req1, ptr_q);

    // Watchdog only measures busy stretches inside a session.
    assign wd_en = (state_q == ST_OWN) && spi_busy;

    sdspi_arbiter_busy_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_busy_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!wd_en),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT_RST;
            rst_cnt_q   <= '0;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            grant_q     <= '0;
            err_q       <= '0;
            init_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            spi_cmd_q   <= '0;
            spi_addr_q  <= '0;
            spi_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            err_q       <= err_d;
            init_done_q <= init_done_d;
            timeout_q   <= timeout_d;
            spi_cmd_q   <= spi_cmd_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: every variable gets a hold/default value first so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        err_d       = err_q;
        init_done_d = init_done_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            ST_INIT_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = ST_INIT_WAIT;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end

            ST_INIT_WAIT: begin
                if (spi_err) begin
                    state_d = ST_INIT_RST;
                end else if (!spi_busy) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_d         = winner;
                    grant_d         = winner ? 2'b10 : 2'b01;
                    err_d[winner]   = 1'b0;
                    state_d         = ST_OWN;
                end
            end

            ST_OWN: begin
                // Errors take precedence over a simultaneous release.
                if (host_err || wd_expire) begin
                    err_d[owner_q] = 1'b1;
                    init_done_d    = 1'b0;
                    state_d        = ST_ERR_HOLD;
                    if (wd_expire) begin
                        timeout_d = 1'b1;
                    end
                end else if (!owner_req) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (!spi_busy) begin
                    ptr_d   = ~owner_q;
                    state_d = ST_IDLE;
                end
            end

            ST_ERR_HOLD: begin
                // Grant is held so the owner sees err before losing the host.
                if (!owner_req) begin
                    ptr_d     = ~owner_q;
                    grant_d   = '0;
                    rst_cnt_d = '0;
                    state_d   = ST_INIT_RST;
                end
            end

            default: begin
                state_d = ST_INIT_RST;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        spi_cmd_d   = '0;
        spi_addr_d  = spi_addr_q;
        spi_wdata_d = spi_wdata_q;

        if (state_q == ST_OWN) begin
            spi_addr_d  = owner_addr;
            spi_wdata_d = owner_wdata;
            // A strobe coinciding with release or an error is dropped, and
            // the non-owner's strobes never reach the host.
            if (owner_req && !host_err && !wd_expire) begin
                spi_cmd_d = owner_cmd;
            end
        end

        spi_rst = (state_q == ST_INIT_RST);
        busy0   = grant_q[0] ? spi_busy : 1'b1;
        busy1   = grant_q[1] ? spi_busy : 1'b1;
    end

    assign grant0            = grant_q[0];
    assign grant1            = grant_q[1];
    assign err0              = err_q[0];
    assign err1              = err_q[1];
    assign rdata             = spi_data_out;
    assign init_done         = init_done_q;
    assign timeout           = timeout_q;
    assign spi_r_multi_block = spi_cmd_q[CMD_R_MULTI];
    assign spi_r_block       = spi_cmd_q[CMD_R_BLOCK];
    assign spi_r_byte        = spi_cmd_q[CMD_R_BYTE];
    assign spi_w_block       = spi_cmd_q[CMD_W_BLOCK];
    assign spi_w_byte        = spi_cmd_q[CMD_W_BYTE];
    assign spi_block_addr    = spi_addr_q;
    assign spi_data_in       = spi_wdata_q;

endmodule : sdspi_arbiter

// File: tb/tb_sdspi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdspi_arbiter
//   Directed bench for sdspi_arbiter (RST_CYCLES=16, TIMEOUT_W=4): reset and
//   init sequence, a table of single-cycle vectors through two sessions, then
//   hand-written sequences for ties, busy release, SD error and watchdog.
// ---------------------------------------------------------------------------
module tb_sdspi_arbiter;

    localparam logic [4:0] C_NONE    = 5'b00000;
    localparam logic [4:0] C_W_BYTE  = 5'b00001;
    localparam logic [4:0] C_W_BLOCK = 5'b00010;
    localparam logic [4:0] C_R_BYTE  = 5'b00100;
    localparam logic [4:0] C_R_BLOCK = 5'b01000;
    localparam logic [4:0] C_R_MULTI = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [4:0]  cmd0, cmd1;
    logic [31:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        grant0, grant1, busy0, busy1, err0, err1;
    logic [7:0]  rdata;
    logic        init_done, timeout;
    logic        spi_rst, spi_r_block, spi_r_multi_block, spi_r_byte;
    logic        spi_w_block, spi_w_byte;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_in;
    logic        spi_busy, spi_err, spi_crc_err;
    logic [7:0]  spi_data_out;
    logic [4:0]  out_cmd;

    int checks   = 0;
    int failures = 0;

    assign out_cmd = {spi_r_multi_block, spi_r_block, spi_r_byte, spi_w_block, spi_w_byte};

    always #5 clk = ~clk;

    sdspi_arbiter #(
        .RST_CYCLES (16),
        .TIMEOUT_W  (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req0              (req0),
        .req1              (req1),
        .cmd0              (cmd0),
        .cmd1              (cmd1),
        .addr0             (addr0),
        .addr1             (addr1),
        .wdata0            (wdata0),
        .wdata1            (wdata1),
        .grant0            (grant0),
        .grant1            (grant1),
        .busy0             (busy0),
        .busy1             (busy1),
        .err0              (err0),
        .err1              (err1),
        .rdata             (rdata),
        .init_done         (init_done),
        .timeout           (timeout),
        .spi_rst           (spi_rst),
        .spi_r_block       (spi_r_block),
        .spi_r_multi_block (spi_r_multi_block),
        .spi_r_byte        (spi_r_byte),
        .spi_w_block       (spi_w_block),
        .spi_w_byte        (spi_w_byte),
        .spi_block_addr    (spi_block_addr),
        .spi_data_in       (spi_data_in),
        .spi_busy          (spi_busy),
        .spi_err           (spi_err),
        .spi_crc_err       (spi_crc_err),
        .spi_data_out      (spi_data_out)
    );

    typedef struct {
        logic        req0, req1;
        logic [4:0]  cmd0, cmd1;
        logic        busy;
        logic        e_g0, e_g1, e_b0, e_b1;
        logic [4:0]  e_cmd;
        logic [31:0] e_addr;
        logic [7:0]  e_data;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic r1,
                                input logic [4:0] c0, input logic [4:0] c1,
                                input logic b,
                                input logic g0, input logic g1,
                                input logic b0, input logic b1,
                                input logic [4:0] ec, input logic [31:0] ea,
                                input logic [7:0] ed);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.cmd0 = c0; v.cmd1 = c1; v.busy = b;
        v.e_g0 = g0; v.e_g1 = g1; v.e_b0 = b0; v.e_b1 = b1;
        v.e_cmd = ec; v.e_addr = ea; v.e_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count consecutive sampled cycles with spi_rst high, bounded.
    task automatic count_rst(output int n);
        n = 0;
        while (spi_rst === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    vec_t vecs[11];
    int   n;
    int   k;

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; cmd0 = '0; cmd1 = '0;
        addr0 = 32'h0000_0010; addr1 = 32'h1234_5678;
        wdata0 = 8'hA5; wdata1 = 8'h5A;
        spi_busy = 1'b1; spi_err = 0; spi_crc_err = 0; spi_data_out = 8'h00;

        // ---------------- reset values
        @(negedge clk);
        repeat (3) tick();
        check("rst_spi_rst",   spi_rst,   1);
        check("rst_grant0",    grant0,    0);
        check("rst_grant1",    grant1,    0);
        check("rst_busy0",     busy0,     1);
        check("rst_busy1",     busy1,     1);
        check("rst_init_done", init_done, 0);
        check("rst_timeout",   timeout,   0);
        check("rst_cmd",       out_cmd,   0);

        // ---------------- init: spi_rst exactly 16 cycles, host busy 100
        rst = 1'b0;
        count_rst(n);
        check("init_rst_len", n, 16);
        repeat (100) tick();
        check("init_wait_busy", init_done, 0);
        spi_busy = 1'b0;
        tick();
        check("init_done_rise", init_done, 1);

        spi_data_out = 8'h3C;
        #1;
        check("rdata_pass", rdata, 8'h3C);

        // ---------------- table: session 0 then session 1
        vecs[0]  = mk(1,0,C_NONE,   C_NONE,   0, 1,0,0,1, C_NONE,   32'h0,         8'h00);
        vecs[1]  = mk(1,0,C_R_BLOCK,C_NONE,   0, 1,0,0,1, C_R_BLOCK,32'h10,        8'hA5);
        vecs[2]  = mk(1,0,C_NONE,   C_NONE,   1, 1,0,1,1, C_NONE,   32'h10,        8'hA5);
        vecs[3]  = mk(1,1,C_NONE,   C_W_BYTE, 0, 1,0,0,1, C_NONE,   32'h10,        8'hA5);
        vecs[4]  = mk(1,1,C_W_BYTE, C_NONE,   0, 1,0,0,1, C_W_BYTE, 32'h10,        8'hA5);
        vecs[5]  = mk(0,1,C_R_BYTE, C_NONE,   0, 0,0,1,1, C_NONE,   32'h10,        8'hA5);
        vecs[6]  = mk(0,1,C_NONE,   C_NONE,   0, 0,0,1,1, C_NONE,   32'h10,        8'hA5);
        vecs[7]  = mk(0,1,C_NONE,   C_NONE,   0, 0,1,1,0, C_NONE,   32'h10,        8'hA5);
        vecs[8]  = mk(0,1,C_NONE,   C_R_MULTI,0, 0,1,1,0, C_R_MULTI,32'h1234_5678, 8'h5A);
        vecs[9]  = mk(0,0,C_NONE,   C_NONE,   0, 0,0,1,1, C_NONE,   32'h1234_5678, 8'h5A);
        vecs[10] = mk(0,0,C_NONE,   C_NONE,   0, 0,0,1,1, C_NONE,   32'h1234_5678, 8'h5A);

        for (int i = 0; i < 11; i++) begin
            req0 = vecs[i].req0; req1 = vecs[i].req1;
            cmd0 = vecs[i].cmd0; cmd1 = vecs[i].cmd1;
            spi_busy = vecs[i].busy;
            tick();
            check($sformatf("v%0d_grant0", i), grant0,         vecs[i].e_g0);
            check($sformatf("v%0d_grant1", i), grant1,         vecs[i].e_g1);
            check($sformatf("v%0d_busy0",  i), busy0,          vecs[i].e_b0);
            check($sformatf("v%0d_busy1",  i), busy1,          vecs[i].e_b1);
            check($sformatf("v%0d_cmd",    i), out_cmd,        vecs[i].e_cmd);
            check($sformatf("v%0d_addr",   i), spi_block_addr, vecs[i].e_addr);
            check($sformatf("v%0d_data",   i), spi_data_in,    vecs[i].e_data);
        end
        cmd0 = '0; cmd1 = '0; spi_busy = 0;

        // ---------------- tie twice: 0 first, then 1; cmd1 blocked in session 0
        req0 = 1; req1 = 1;
        tick();
        check("tie1_grant0", grant0, 1);
        check("tie1_grant1", grant1, 0);
        cmd1 = C_R_BLOCK; tick(); check("tie1_cmd1_blk_a", out_cmd, 0);
        cmd1 = C_W_BLOCK; tick(); check("tie1_cmd1_blk_b", out_cmd, 0);
        cmd1 = '0;
        req0 = 0; req1 = 0;
        tick(); tick();
        req0 = 1; req1 = 1;
        tick();
        check("tie2_grant1", grant1, 1);
        check("tie2_grant0", grant0, 0);
        req0 = 0; req1 = 0;
        tick(); tick();

        // ---------------- release while host busy
        req0 = 1; req1 = 1;
        tick();
        check("rb_grant0", grant0, 1);
        spi_busy = 1;
        tick();
        req0 = 0;
        tick();
        check("rb_grant0_drop", grant0, 0);
        repeat (4) tick();
        check("rb_grant1_held", grant1, 0);
        spi_busy = 0;
        k = 0;
        while (grant1 !== 1'b1 && k < 2) begin
            k++;
            tick();
        end
        check("rb_grant1_rise", grant1, 1);

        // ---------------- SD error in session owned by 1
        spi_err = 1;
        tick();
        spi_err = 0;
        check("er_err1",       err1,      1);
        check("er_grant1",     grant1,    1);
        check("er_init_done",  init_done, 0);
        cmd1 = C_R_BLOCK;
        tick();
        cmd1 = '0;
        check("er_cmd_forced", out_cmd, 0);
        tick();
        check("er_grant1_hold", grant1, 1);
        check("er_spi_rst_low", spi_rst, 0);
        req1 = 0;
        tick();
        check("er_spi_rst", spi_rst, 1);
        check("er_grant1_off", grant1, 0);
        count_rst(n);
        check("er_rst_len", n, 16);
        check("er_init_pending", init_done, 0);
        tick();
        check("er_init_back", init_done, 1);
        check("er_err1_sticky", err1, 1);
        req1 = 1;
        tick();
        check("er_regrant1", grant1, 1);
        check("er_err1_clear", err1, 0);

        // ---------------- watchdog with busy stuck high (2^4 cycles)
        spi_busy = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) check("wd_not_yet", timeout, 0);
        end
        check("wd_timeout", timeout, 1);
        check("wd_err1",    err1,    1);
        check("wd_grant1",  grant1,  1);
        req1 = 0;
        tick();
        check("wd_spi_rst", spi_rst, 1);
        spi_busy = 0;
        count_rst(n);
        check("wd_rst_len", n, 16);
        tick();
        check("wd_init_back", init_done, 1);
        check("wd_timeout_sticky", timeout, 1);

        // ---------------- rst mid-session
        req0 = 1;
        tick();
        check("mr_grant0", grant0, 1);
        rst = 1;
        tick();
        check("mr_grant0_lost", grant0,  0);
        check("mr_spi_rst",     spi_rst, 1);
        check("mr_timeout_clr", timeout, 0);
        check("mr_busy0",       busy0,   1);
        rst = 0; req0 = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sdspi_arbiter
